// File: rtl/song_reader_if.sv
// Signal bundle between the song reader and its environment (mcu, song ROM,
// note player). The slave modport is the reader; master is the environment.
interface song_reader_if #(
    parameter int NOTES_PER_SONG = 32,
    parameter int NOTE_W         = 6
);
    localparam int ADDR_W = 2 + $clog2(NOTES_PER_SONG);

    logic                play;
    logic [1:0]          song;
    logic                note_done;
    logic [ADDR_W-1:0]   rom_addr;
    logic [2*NOTE_W-1:0] rom_data;
    logic [NOTE_W-1:0]   note;
    logic [NOTE_W-1:0]   duration;
    logic                new_note;
    logic                song_done;

    modport master (
        output play, song, note_done, rom_data,
        input  rom_addr, note, duration, new_note, song_done
    );

    modport slave (
        input  play, song, note_done, rom_data,
        output rom_addr, note, duration, new_note, song_done
    );
endinterface

// File: rtl/song_reader.sv
// Song reader: walks one song in an external synchronous ROM, announces each
// note to the player with a one-cycle strobe, and flags the end of the song.
module song_reader #(
    parameter int NOTES_PER_SONG = 32,
    parameter int NOTE_W         = 6
) (
    input  logic         clk,
    input  logic         reset,
    song_reader_if.slave bus
);
    localparam int               IDX_W    = $clog2(NOTES_PER_SONG);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NOTES_PER_SONG - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_ANNOUNCE,
        S_PLAYING,
        S_DONE,
        S_HALT
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        cur_song_q, cur_song_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [NOTE_W-1:0] note_q, note_d;
    logic [NOTE_W-1:0] duration_q, duration_d;

    logic [NOTE_W-1:0] rom_note;
    logic [NOTE_W-1:0] rom_dur;

    assign rom_note = bus.rom_data[2*NOTE_W-1:NOTE_W];
    assign rom_dur  = bus.rom_data[NOTE_W-1:0];

    // NOTE: every signal written here gets its hold value first, so no path
    // through the case leaves it unassigned and infers a latch.
    always_comb begin
        state_d    = state_q;
        cur_song_d = cur_song_q;
        idx_d      = idx_q;
        note_d     = note_q;
        duration_d = duration_q;

        case (state_q)
            S_IDLE: begin
                cur_song_d = bus.song;
                idx_d      = '0;
                if (bus.play) state_d = S_FETCH;
            end
            S_FETCH: begin
                if (bus.play) state_d = S_LOAD;
            end
            S_LOAD: begin
                // A zero duration marks the end of a short song.
                if (rom_dur == '0) begin
                    state_d = S_DONE;
                end else begin
                    note_d     = rom_note;
                    duration_d = rom_dur;
                    state_d    = S_ANNOUNCE;
                end
            end
            S_ANNOUNCE: state_d = S_PLAYING;
            S_PLAYING: begin
                if (bus.note_done && bus.play) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = S_FETCH;
                    end
                end
            end
            S_DONE:  state_d = S_HALT;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: registers use non-blocking assignments so every flop samples the
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cur_song_q <= '0;
            idx_q      <= '0;
            note_q     <= '0;
            duration_q <= '0;
        end else begin
            state_q    <= state_d;
            cur_song_q <= cur_song_d;
            idx_q      <= idx_d;
            note_q     <= note_d;
            duration_q <= duration_d;
        end
    end

    assign bus.rom_addr  = {cur_song_q, idx_q};
    assign bus.note      = note_q;
    assign bus.duration  = duration_q;
    assign bus.new_note  = (state_q == S_ANNOUNCE);
    assign bus.song_done = (state_q == S_DONE);
endmodule

// File: tb/tb_song_reader.sv
// Randomized bench for song_reader: a ROM image plus a prefix-of-song model
// predicts every fetch address, announced note, latency and end-of-song pulse.
module tb_song_reader;
    localparam int NPS = 32;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    song_reader_if #(.NOTES_PER_SONG(NPS), .NOTE_W(6)) bus ();

    song_reader #(.NOTES_PER_SONG(NPS), .NOTE_W(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [11:0] rom [128];

    always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Strobes: never together, never high two cycles running.
    bit   mon_en  = 1'b0;
    logic prev_nn = 1'b0;
    logic prev_sd = 1'b0;
    int   nn_count = 0;
    int   sd_count = 0;

    always @(negedge clk) begin
        if (mon_en) begin
            check("strobe_rules", {29'd0, bus.new_note & bus.song_done,
                                   bus.new_note & prev_nn, bus.song_done & prev_sd}, 32'd0);
            if (bus.new_note === 1'b1)  nn_count <= nn_count + 1;
            if (bus.song_done === 1'b1) sd_count <= sd_count + 1;
            prev_nn <= bus.new_note;
            prev_sd <= bus.song_done;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_addr"}, bus.rom_addr, 0);
        check({tag, "_note"}, bus.note, 0);
        check({tag, "_dur"}, bus.duration, 0);
        check({tag, "_nn"}, bus.new_note, 0);
        check({tag, "_sd"}, bus.song_done, 0);
    endtask

    // Plays song s from reset; if stop_at matches an announced slot, resets there.
    task automatic run_song(input logic [1:0] s, input int stop_at);
        int          base;
        int          n_notes;
        int          pause;
        int          nn0;
        int          sd0;
        int          end_addr;
        bit          term;
        logic [11:0] w;
        logic [5:0]  last_note;
        logic [5:0]  last_dur;

        base    = int'(s) * NPS;
        n_notes = 0;
        term    = 1'b0;
        for (int i = 0; i < NPS; i++) begin
            w = rom[base + i];
            if (w[5:0] == 6'd0) begin
                term = 1'b1;
                break;
            end
            n_notes++;
        end

        reset         = 1'b1;
        bus.song      = ~s;
        bus.play      = 1'($urandom_range(0, 1));
        bus.note_done = 1'($urandom_range(0, 1));
        tick();
        check_cleared("reset");
        reset         = 1'b0;
        bus.play      = 1'b0;
        bus.note_done = 1'b0;
        bus.song      = s;
        repeat ($urandom_range(1, 3)) tick();
        check("idle_nn", bus.new_note, 0);

        nn0       = nn_count;
        sd0       = sd_count;
        last_note = '0;
        last_dur  = '0;
        bus.play  = 1'b1;

        for (int i = 0; i < n_notes + (term ? 1 : 0); i++) begin
            if (i > 0) bus.note_done = 1'b1;
            tick();
            bus.note_done = 1'b0;
            check("fetch_addr", bus.rom_addr, base + i);
            check("fetch_nn", bus.new_note, 0);

            pause = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : 0;
            if (pause > 0) begin
                bus.play = 1'b0;
                repeat (pause) begin
                    tick();
                    check("pause_addr", bus.rom_addr, base + i);
                    check("pause_nn", bus.new_note, 0);
                end
                bus.play = 1'b1;
            end

            tick();
            check("load_nn", bus.new_note, 0);
            bus.play = 1'($urandom_range(0, 1));
            tick();
            w = rom[base + i];

            if (i == n_notes) begin
                check("term_sd", bus.song_done, 1);
                check("term_nn", bus.new_note, 0);
                check("term_note", bus.note, last_note);
                check("term_dur", bus.duration, last_dur);
            end else begin
                check("nn", bus.new_note, 1);
                check("note", bus.note, w[11:6]);
                check("dur", bus.duration, w[5:0]);
                last_note     = w[11:6];
                last_dur      = w[5:0];
                bus.play      = 1'b1;
                bus.note_done = 1'($urandom_range(0, 1));
                tick();
                bus.note_done = 1'b0;
                check("nn_once", bus.new_note, 0);
                check("hold_addr", bus.rom_addr, base + i);

                if ($urandom_range(0, 2) == 0) begin
                    bus.play      = 1'b0;
                    bus.note_done = 1'b1;
                    tick();
                    bus.note_done = 1'b0;
                    tick();
                    check("paused_addr", bus.rom_addr, base + i);
                    check("paused_nn", bus.new_note, 0);
                    bus.play = 1'b1;
                end
                repeat ($urandom_range(0, 3)) tick();

                if (stop_at == i) begin
                    reset = 1'b1;
                    tick();
                    check_cleared("midrst");
                    reset = 1'b0;
                    return;
                end
            end
        end

        if (!term) begin
            bus.note_done = 1'b1;
            tick();
            bus.note_done = 1'b0;
            check("last_sd", bus.song_done, 1);
            check("last_nn", bus.new_note, 0);
        end

        end_addr = term ? base + n_notes : base + NPS - 1;
        repeat (8) begin
            bus.play      = 1'($urandom_range(0, 1));
            bus.note_done = 1'($urandom_range(0, 1));
            tick();
            check("halt_sd", bus.song_done, 0);
            check("halt_addr", bus.rom_addr, end_addr);
        end
        bus.note_done = 1'b0;
        check("halt_note", bus.note, last_note);
        check("halt_dur", bus.duration, last_dur);
        check("nn_total", nn_count - nn0, n_notes);
        check("sd_total", sd_count - sd0, 1);
    endtask

    initial begin
        int sn;
        int stop;

        reset         = 1'b1;
        bus.play      = 1'b0;
        bus.song      = 2'd0;
        bus.note_done = 1'b0;
        for (int a = 0; a < 128; a++) rom[a] = {6'($urandom), 6'($urandom_range(1, 63))};
        rom[64] = {6'd20, 6'd10};
        rom[3]  = {6'($urandom), 6'd0};
        tick();
        mon_en = 1'b1;

        run_song(2'd2, -1);
        run_song(2'd1, -1);
        run_song(2'd0, -1);
        run_song(2'd3, 7);
        run_song(2'd1, -1);

        for (int k = 0; k < 6; k++) begin
            sn = int'($urandom_range(0, 3));
            for (int j = 0; j < NPS; j++)
                rom[sn * NPS + j] = {6'($urandom), 6'($urandom_range(1, 63))};
            if ($urandom_range(0, 2) != 0)
                rom[sn * NPS + int'($urandom_range(0, NPS - 1))][5:0] = 6'd0;
            stop = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 10)) : -1;
            run_song(2'(sn), stop);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/song_reader.md
# song_reader

Downstream neighbour of `mcu`. It consumes `play` and `song`, fetches the selected song's notes one at a time from an external synchronous song ROM, and hands each note to the note player with a one-cycle `new_note` strobe. It reports `song_done` back to `mcu` after the last note of the song finishes. At top level, `reset` on this block is driven by `reset | reset_player`, so an `mcu` song change restarts the reader.

## Interface
Parameters:
- `NOTES_PER_SONG`, 32: note slots per song; must be a power of two.
- `NOTE_W`, 6: width of the note code and of the duration field.

Ports:
- `clk`, input, 1: single system clock; all state changes on its rising edge.
- `reset`, input, 1: synchronous, active-high; reset is synchronous and active-high.
- `play`, input, 1: from `mcu`; 1 = advance through the song, 0 = pause.
- `song`, input, 2: song select from `mcu`; only sampled in IDLE.
- `note_done`, input, 1: one-cycle pulse from the note player; the current note has finished.
- `rom_addr`, output, 7: song ROM address, equal to {cur_song, idx}; driven combinationally from registers.
- `rom_data`, input, 12: song ROM word {note[11:6], duration[5:0]}; valid one cycle after `rom_addr`.
- `note`, output, 6: current note code; registered.
- `duration`, output, 6: current note duration; registered.
- `new_note`, output, 1: one-cycle strobe; `note`/`duration` are valid and newly loaded.
- `song_done`, output, 1: one-cycle pulse; the song is finished.

## Operation
- Internal registers:
  - `cur_song[1:0]`.
  - `idx[4:0]`, width log2(NOTES_PER_SONG).
  - `note`, `duration`.
  - state.
- States: IDLE, FETCH, LOAD, ANNOUNCE, PLAYING, DONE, HALT.
- IDLE:
  - `cur_song <= song` every cycle; `idx` = 0.
  - Goes to FETCH if `play`=1, otherwise stays.
- FETCH: drives `rom_addr`. Goes to LOAD if `play`=1, otherwise stays (pause holds the address).
- LOAD: captures `rom_data` into `note` and `duration`.
  - If `rom_data[5:0]` = 0 (terminator), goes to DONE and leaves `note`/`duration` unchanged.
  - Otherwise goes to ANNOUNCE. This state is unconditional (ignores `play`).
- ANNOUNCE: `new_note`=1 for exactly this cycle, then unconditionally goes to PLAYING.
- PLAYING: waits for `note_done`=1 with `play`=1.
  - If `idx` = NOTES_PER_SONG-1, goes to DONE.
  - Otherwise `idx <= idx+1` and goes to FETCH.
- DONE: `song_done`=1 for exactly this cycle, then unconditionally goes to HALT.
- HALT:
  - All outputs hold except the strobes, which stay 0.
  - Leaves only via `reset`; `mcu` issues `reset_player` on the resulting song change.
- `note_done` is ignored in every state except PLAYING, and also ignored in PLAYING while `play`=0.
- `idx` never wraps; the last-slot check is made before incrementing.
- `song` changes outside IDLE have no effect until the next reset.

## Timing
- Reset values:
  - state = IDLE.
  - `cur_song` = 0, `idx` = 0, so `rom_addr` = 0.
  - `note` = 0, `duration` = 0.
  - `new_note` = 0, `song_done` = 0.
- Reset wins over every transition, including mid-note and during DONE. `song_done` is not asserted on reset.
- Start latency: if the edge at cycle t samples `play`=1 in IDLE:
  - FETCH in cycle t+1.
  - LOAD in cycle t+2.
  - ANNOUNCE (`new_note`=1) in cycle t+3.
- Next-note latency: if the edge at cycle t samples `note_done`=1 in PLAYING, `new_note` rises in cycle t+3, assuming `play` stays 1.
- Pause: `play`=0 during FETCH stretches that state. LOAD and ANNOUNCE complete regardless, so a fetch already issued is always announced.
- `song_done` rises one cycle after the edge that accepts the final `note_done`, or two cycles after FETCH of a terminator word.
- `new_note` and `song_done` are never high together, and neither is ever high for two consecutive cycles.

## Test plan
1. Reset, then `song`=2 and `play`=1, with ROM[64] = {6'd20, 6'd10} → `rom_addr`=64 in cycle t+1; `new_note`=1 with `note`=20 and `duration`=10 in cycle t+3; then PLAYING.
2. Pulse `note_done` in PLAYING → `rom_addr`=65, then a single `new_note` with ROM[65]'s contents 3 cycles after the `note_done` edge.
3. Song 1 with all 32 slots nonzero; pulse `note_done` 32 times → exactly 32 `new_note` pulses; then one `song_done` pulse; `rom_addr` stops at 63 and no further strobes follow.
4. Song 0 with ROM[3] duration = 0 → 3 notes announced, then `song_done` 2 cycles after FETCH of address 3; `note`/`duration` keep ROM[2]'s values.
5. Pause: drop `play` in PLAYING and pulse `note_done` → ignored, no fetch. Raise `play` and pulse `note_done` again → normal advance. Drop `play` in FETCH → `rom_addr` held and `new_note` delayed by the pause length.
6. Reset asserted mid-song at `idx`=7 → next cycle all outputs are 0 and state is IDLE. After release, the new `song` value is sampled and playback starts at `idx`=0.
